motion_zone_tracker: RTL

MOTION_ZONE_TRACKER -- requirements
Module: motion_zone_tracker

---
 rtl/motion_zone_tracker.sv | 343 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/motion_zone_tracker.sv
// ---------------------------------------------------------------------------
// motion_zone_tracker
//
// Purpose:
//   Splits the active image into ZONES equal-width vertical strips and, for
//   each strip, tracks the bounding box of "motion" pixels. A pixel is
//   motion when |cur - prev| exceeds a threshold that is latched at the start
//   of each frame. At the end of the frame the per-zone results are published
//   with a one-cycle box_valid pulse. Results then hold until the next pulse.
//
// Optional feature (macro MOTION_ZONE_PIXCOUNT_EN):
//   Adds saturating per-zone motion pixel counters and the pix_count output.
//   A zone then counts as hit only when its count reaches MIN_PIX. Without
//   the macro the counters are not built and a zone is hit by any motion
//   pixel.
//
// Ports:
//   clk        sole clock
//   rst        synchronous active-high reset
//   in_vsync   high during the active frame
//   in_href    high during the active line
//   in_clken   pixel strobe
//   in_gray    {prev, cur} gray samples, GRAY_W bits each
//   threshold  difference threshold (latched on vsync rising edge)
//   box_valid  one-cycle pulse when the outputs below update
//   zone_hit   per-zone motion flag
//   box_xmin / box_xmax  per-zone x bounds, XW bits each, zone 0 in LSBs
//   box_ymin / box_ymax  per-zone y bounds, YW bits each, zone 0 in LSBs
//   pix_count  per-zone motion pixel count, CW bits each (macro only)
// ---------------------------------------------------------------------------
module motion_zone_tracker #(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int ZONES     = 4,
   parameter int GRAY_W    = 8,
   parameter int MIN_PIX   = 16,
   localparam int XW = $clog2(IMG_HDISP),
   localparam int YW = $clog2(IMG_VDISP),
   localparam int CW = $clog2(IMG_HDISP*IMG_VDISP+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_vsync,
   input  logic                  in_href,
   input  logic                  in_clken,
   input  logic [2*GRAY_W-1:0]   in_gray,
   input  logic [GRAY_W-1:0]     threshold,
   output logic                  box_valid,
   output logic [ZONES-1:0]      zone_hit,
   output logic [ZONES*XW-1:0]   box_xmin,
   output logic [ZONES*XW-1:0]   box_xmax,
   output logic [ZONES*YW-1:0]   box_ymin,
   output logic [ZONES*YW-1:0]   box_ymax
`ifdef MOTION_ZONE_PIXCOUNT_EN
   ,output logic [ZONES*CW-1:0]  pix_count
`endif
);

   localparam int ZW  = IMG_HDISP / ZONES;
   localparam int ZIW = (ZONES > 1) ? $clog2(ZONES) : 1;

   // Counters carry one extra bit so they can sit at the saturation value
   // IMG_HDISP / IMG_VDISP, which marks every later sample as out of range.
   localparam logic [XW:0]    X_LIM   = (XW+1)'(IMG_HDISP);
   localparam logic [YW:0]    Y_LIM   = (YW+1)'(IMG_VDISP);
   localparam logic [XW:0]    ZW_LAST = (XW+1)'(ZW-1);
   localparam logic [ZIW-1:0] Z_LAST  = ZIW'(ZONES-1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACTIVE  = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_PUBLISH = 2'd3;

   if ((IMG_HDISP % ZONES) != 0 || MIN_PIX < 0 || CW < 1) begin : g_cfg_bad
      $error("motion_zone_tracker: IMG_HDISP must be divisible by ZONES");
   end

   // ------------------------------------------------------------------
   // Sync edge detection and pixel position counters
   // ------------------------------------------------------------------
   logic            r_vsync_d;
   logic            r_href_d;
   logic [XW:0]     r_x;
   logic [YW:0]     r_y;
   logic [XW:0]     r_zpos;
   logic [ZIW-1:0]  r_zone;
   logic [GRAY_W-1:0] r_thresh;

   logic w_vs_rise;
   logic w_vs_fall;
   logic w_href_fall;
   logic w_sample;
   logic w_in_range;
   logic [YW:0] w_y_eff;

   assign w_vs_rise   = in_vsync & ~r_vsync_d;
   assign w_vs_fall   = ~in_vsync & r_vsync_d;
   assign w_href_fall = ~in_href & r_href_d;
   assign w_sample    = in_clken & in_href & in_vsync;
   // The y counter clears on the vsync rising edge; a pixel sampled on that
   // very edge already belongs to line 0.
   assign w_y_eff     = w_vs_rise ? '0 : r_y;
   assign w_in_range  = (r_x < X_LIM) && (w_y_eff < Y_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         // vsync history starts high so a frame already in progress when
         // reset is released never looks like a fresh frame start.
         r_vsync_d <= 1'b1;
         r_href_d  <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_zpos    <= '0;
         r_zone    <= '0;
         r_thresh  <= '0;
      end else begin
         r_vsync_d <= in_vsync;
         r_href_d  <= in_href;

         if (w_vs_rise) begin
            r_thresh <= threshold;
         end

         if (!in_href) begin
            r_x    <= '0;
            r_zpos <= '0;
            r_zone <= '0;
         end else if (w_sample) begin
            if (r_x != X_LIM) begin
               r_x <= r_x + 1'b1;
            end
            // Strip counter replaces x / ZW
            if (r_zpos == ZW_LAST) begin
               r_zpos <= '0;
               if (r_zone != Z_LAST) begin
                  r_zone <= r_zone + 1'b1;
               end
            end else begin
               r_zpos <= r_zpos + 1'b1;
            end
         end

         if (w_vs_rise) begin
            r_y <= '0;
         end else if (w_href_fall && (r_y != Y_LIM)) begin
            r_y <= r_y + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   logic [1:0] r_state;
   logic       r_drain;
   logic       r_pend;
   logic       r_box_valid;
   logic       w_go;
   logic       w_accept;
   logic       w_publish;

   // w_go marks the edge at which a new frame's accumulation starts; a
   // vsync rise seen while draining is remembered in r_pend and acted on
   // when PUBLISH completes.
   assign w_go      = ((r_state == S_IDLE) && w_vs_rise) ||
                      ((r_state == S_PUBLISH) && (w_vs_rise || r_pend));
   assign w_accept  = (r_state == S_ACTIVE) || w_go;
   assign w_publish = (r_state == S_PUBLISH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_drain     <= 1'b0;
         r_pend      <= 1'b0;
         r_box_valid <= 1'b0;
      end else begin
         r_box_valid <= w_publish;
         case (r_state)
            S_IDLE: begin
               if (w_vs_rise) begin
                  r_state <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (w_vs_fall) begin
                  r_state <= S_DRAIN;
                  r_drain <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (w_vs_rise) begin
                  r_pend <= 1'b1;
               end
               if (r_drain) begin
                  r_state <= S_PUBLISH;
               end else begin
                  r_drain <= 1'b1;
               end
            end
            S_PUBLISH: begin
               r_pend  <= 1'b0;
               r_state <= w_go ? S_ACTIVE : S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign box_valid = r_box_valid;

   // ------------------------------------------------------------------
   // Stage 1: absolute difference and coordinates
   // ------------------------------------------------------------------
   logic [GRAY_W-1:0] w_cur;
   logic [GRAY_W-1:0] w_prev;
   logic [GRAY_W:0]   w_diff;

   logic              r_s1_vld;
   logic [GRAY_W:0]   r_s1_diff;
   logic [XW-1:0]     r_s1_x;
   logic [YW-1:0]     r_s1_y;
   logic [ZIW-1:0]    r_s1_zone;

   assign w_cur  = in_gray[GRAY_W-1:0];
   assign w_prev = in_gray[2*GRAY_W-1:GRAY_W];
   assign w_diff = (w_cur >= w_prev) ? ({1'b0, w_cur} - {1'b0, w_prev})
                                     : ({1'b0, w_prev} - {1'b0, w_cur});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_diff <= '0;
         r_s1_x    <= '0;
         r_s1_y    <= '0;
         r_s1_zone <= '0;
      end else begin
         r_s1_vld  <= w_sample & w_in_range & w_accept;
         r_s1_diff <= w_diff;
         r_s1_x    <= r_x[XW-1:0];
         r_s1_y    <= w_y_eff[YW-1:0];
         r_s1_zone <= r_zone;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: per-zone accumulators and published results
   // ------------------------------------------------------------------
   genvar gi;
   for (gi = 0; gi < ZONES; gi = gi + 1) begin : g_zone
      logic [XW-1:0] r_xmin;
      logic [XW-1:0] r_xmax;
      logic [YW-1:0] r_ymin;
      logic [YW-1:0] r_ymax;
      logic [XW-1:0] r_oxmin;
      logic [XW-1:0] r_oxmax;
      logic [YW-1:0] r_oymin;
      logic [YW-1:0] r_oymax;
      logic          r_ohit;
      logic          w_upd;
      logic          w_hit;

      // Threshold compare happens here against the frame-latched value.
      assign w_upd = r_s1_vld && (r_s1_zone == ZIW'(gi)) &&
                     (r_s1_diff > {1'b0, r_thresh});

`ifdef MOTION_ZONE_PIXCOUNT_EN
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] r_ocnt;

      assign w_hit = (r_cnt >= CW'(MIN_PIX));

      always_ff @(posedge clk) begin
         if (rst || w_go) begin
            r_cnt <= '0;
         end else if (w_upd && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_ocnt <= '0;
         end else if (w_publish) begin
            r_ocnt <= r_cnt;
         end
      end

      assign pix_count[gi*CW +: CW] = r_ocnt;
`else
      logic r_any;

      assign w_hit = r_any;

      always_ff @(posedge clk) begin
         if (rst || w_go) begin
            r_any <= 1'b0;
         end else if (w_upd) begin
            r_any <= 1'b1;
         end
      end
`endif

      always_ff @(posedge clk) begin
         if (rst || w_go) begin
            r_xmin <= '1;
            r_ymin <= '1;
            r_xmax <= '0;
            r_ymax <= '0;
         end else if (w_upd) begin
            if (r_s1_x < r_xmin) r_xmin <= r_s1_x;
            if (r_s1_x > r_xmax) r_xmax <= r_s1_x;
            if (r_s1_y < r_ymin) r_ymin <= r_s1_y;
            if (r_s1_y > r_ymax) r_ymax <= r_s1_y;
         end
      end

      // Zones without a hit publish zero bounds instead of the init values.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_ohit  <= 1'b0;
            r_oxmin <= '0;
            r_oxmax <= '0;
            r_oymin <= '0;
            r_oymax <= '0;
         end else if (w_publish) begin
            r_ohit  <= w_hit;
            r_oxmin <= w_hit ? r_xmin : '0;
            r_oxmax <= w_hit ? r_xmax : '0;
            r_oymin <= w_hit ? r_ymin : '0;
            r_oymax <= w_hit ? r_ymax : '0;
         end
      end

      assign zone_hit[gi]             = r_ohit;
      assign box_xmin[gi*XW +: XW]    = r_oxmin;
      assign box_xmax[gi*XW +: XW]    = r_oxmax;
      assign box_ymin[gi*YW +: YW]    = r_oymin;
      assign box_ymax[gi*YW +: YW]    = r_oymax;
   end

endmodule
